// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and its matching receiver.
// Frame layout, in line order: start (0), even parity, data[6:0] MSB first,
// stop (1). The line idles high.
// Contents:
//   FRAME_BITS, DATA_BITS       frame geometry
//   START_BIT, STOP_BIT,        line levels for the framing bits and idle
//   IDLE_LEVEL
//   tx_state_t                  transmitter FSM states
//   even_parity()               parity bit that makes the 8-bit group XOR to 0
package uart_pkg;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 7;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        PARITY = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity bit chosen so that parity ^ data has even weight.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Character buffer in front of the UART serialiser.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; flushes the buffer, clears overflow
//   push       enqueue strobe; accepted only when full is low at that edge
//   push_data  character to enqueue
//   pop        dequeue strobe; ignored while empty
//   pop_data   head entry (valid whenever empty is low)
//   full       DEPTH entries held
//   empty      no entries held
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a push arrived while full
// Handshake: push and pop have no back-pressure. A push while full is
// dropped and flagged; a pop while empty is ignored. Both flags come from
// the registered count, so a push at full is rejected even if a pop happens
// on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [CW-1:0]        count,
    output logic                 overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 overflow_q, overflow_d;
    logic                 push_ok;
    logic                 pop_ok;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        pop_data = mem_q[rd_ptr_q];

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q || (push && full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: flushing the pointers makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Buffers 7-bit characters and serialises them onto tx as
// start, even parity, data[6:0] MSB first, stop. The line advances one bit
// per tx_en strobe.
// Ports:
//   tx_clk    rising-edge clock
//   resetN    synchronous active-low reset; abandons any frame, flushes FIFO
//   data_in   character to enqueue
//   wr_en     enqueue strobe (dropped and flagged in overflow when full)
//   tx_en     bit-period strobe; the serialiser only moves when it is high
//   tx        registered serial line, idles high
//   busy      high from the start bit through the stop bit of each frame
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   count     FIFO occupancy
//   overflow  sticky write-while-full flag, cleared only by reset
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 tx_clk,
    input  logic                 resetN,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 tx_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 full,
    output logic                 empty,
    output logic [CW-1:0]        count,
    output logic                 overflow
);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           idx_q,   idx_d;
    logic                 tx_q,    tx_d;
    logic                 busy_q,  busy_d;
    logic                 pop;
    logic [DATA_BITS-1:0] fifo_data;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (tx_clk),
        .rst_n     (resetN),
        .push      (wr_en),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // tx_q always holds the bit currently on the line; state_q names which
    // frame bit that is. Each tx_en edge loads the next bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        if (tx_en) begin
            case (state_q)
                // STOP ends like IDLE so queued frames follow with no gap.
                // The character is captured here, so later FIFO traffic
                // cannot disturb the frame on the line.
                IDLE, STOP: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_data;
                        tx_d    = START_BIT;
                        busy_d  = 1'b1;
                        state_d = START;
                    end else begin
                        tx_d    = IDLE_LEVEL;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                START: begin
                    tx_d    = even_parity(shreg_q);
                    state_d = PARITY;
                end
                PARITY: begin
                    tx_d    = shreg_q[DATA_BITS-1];
                    idx_d   = 3'(DATA_BITS - 1);
                    state_d = DATA;
                end
                DATA: begin
                    // idx_q is the data bit now on the line; 0 means d[0]
                    // has had its full period.
                    if (idx_q == 3'd0) begin
                        tx_d    = STOP_BIT;
                        state_d = STOP;
                    end else begin
                        tx_d  = shreg_q[idx_q - 3'd1];
                        idx_d = idx_q - 3'd1;
                    end
                end
                default: begin
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
